// File: rtl/adrv9009_rx_pwr_meas.sv
//==============================================================================
// Module   : adrv9009_rx_pwr_meas
// Brief    : Windowed mean-square RX power meter; optional window peak
//            magnitude reporting enabled with macro RX_PWR_PEAK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adrv9009_rx_pwr_meas #(
    parameter int DATA_W  = 16,
    parameter int WIN_MIN = 4,
    parameter int WIN_MAX = 12,
    parameter int ACC_W   = 2*DATA_W + WIN_MAX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic                     in_valid_i,
    input  logic                     start_i,
    input  logic                     cont_i,
    input  logic                     en_i,
    input  logic [3:0]               win_log2_i,
    output logic [31:0]              pwr_out_o,
    output logic                     pwr_valid_o,
    output logic                     busy_o,
    output logic [DATA_W-1:0]        peak_out_o
);

    localparam int         CNT_W     = WIN_MAX + 1;
    localparam logic [3:0] C_WIN_MIN = 4'(WIN_MIN);
    localparam logic [3:0] C_WIN_MAX = 4'(WIN_MAX);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [3:0]              n_q;
    logic [31:0]             pwr_q;
    logic                    pwr_valid_q;

    function automatic logic [3:0] clamp_n(input logic [3:0] n);
        if (n < C_WIN_MIN)      return C_WIN_MIN;
        else if (n > C_WIN_MAX) return C_WIN_MAX;
        else                    return n;
    endfunction

    // Sign-extend before squaring so the 2*DATA_W product is exact; it is
    // always non-negative so it can be zero-extended into the accumulator.
    logic signed [2*DATA_W-1:0] in_ext;
    logic signed [2*DATA_W-1:0] sq_s;
    logic [ACC_W-1:0]           sq_ext;
    logic [ACC_W-1:0]           acc_sum;
    logic [CNT_W-1:0]           cnt_last;
    logic                       win_start;
    logic                       abort;
    logic                       accept;
    logic                       win_end;

    assign in_ext    = {{DATA_W{in_i[DATA_W-1]}}, in_i};
    assign sq_s      = in_ext * in_ext;
    assign sq_ext    = {{(ACC_W-2*DATA_W){1'b0}}, sq_s};
    assign acc_sum   = acc_q + sq_ext;
    assign cnt_last  = (CNT_W'(1) << n_q) - CNT_W'(1);
    assign win_start = (state_q == ST_IDLE) && start_i && en_i;
    assign abort     = (state_q == ST_ACCUM) && !en_i;
    assign accept    = (state_q == ST_ACCUM) && en_i && in_valid_i;
    assign win_end   = accept && (cnt_q == cnt_last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            n_q         <= C_WIN_MIN;
            pwr_q       <= '0;
            pwr_valid_q <= 1'b0;
        end else begin
            pwr_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_start) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        n_q     <= clamp_n(win_log2_i);
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (abort) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (win_end) begin
                        // Last sample of the window folds straight into the result.
                        pwr_q       <= 32'(acc_sum >> n_q);
                        pwr_valid_q <= 1'b1;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        if (cont_i) begin
                            n_q <= clamp_n(win_log2_i);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (accept) begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pwr_out_o   = pwr_q;
    assign pwr_valid_o = pwr_valid_q;
    assign busy_o      = (state_q == ST_ACCUM);

`ifdef RX_PWR_PEAK_EN
    logic [DATA_W-1:0] peak_q;
    logic [DATA_W-1:0] peak_out_q;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] peak_max;

    // Most-negative input has no positive twin; saturate its magnitude.
    always_comb begin
        mag = in_i;
        if (in_i[DATA_W-1]) begin
            if (in_i == {1'b1, {(DATA_W-1){1'b0}}}) begin
                mag = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                mag = DATA_W'(-in_i);
            end
        end
    end

    assign peak_max = (mag > peak_q) ? mag : peak_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            peak_q     <= '0;
            peak_out_q <= '0;
        end else if (win_start || abort) begin
            peak_q <= '0;
        end else if (win_end) begin
            peak_out_q <= peak_max;
            peak_q     <= '0;
        end else if (accept) begin
            peak_q <= peak_max;
        end
    end

    assign peak_out_o = peak_out_q;
`else
    assign peak_out_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adrv9009_rx_pwr_meas.sv
//==============================================================================
// Module   : tb_adrv9009_rx_pwr_meas
// Brief    : Scoreboard bench for adrv9009_rx_pwr_meas; a sample-list model
//            predicts each window result, a monitor checks DUT output pulses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adrv9009_rx_pwr_meas;

    logic               clk;
    logic               reset;
    logic signed [15:0] in_d;
    logic               in_valid;
    logic               start;
    logic               cont;
    logic               en;
    logic [3:0]         win_log2;
    logic [31:0]        pwr_out;
    logic               pwr_valid;
    logic               busy;
    logic [15:0]        peak_out;

    adrv9009_rx_pwr_meas dut (
        .clk         (clk),
        .reset       (reset),
        .in_i        (in_d),
        .in_valid_i  (in_valid),
        .start_i     (start),
        .cont_i      (cont),
        .en_i        (en),
        .win_log2_i  (win_log2),
        .pwr_out_o   (pwr_out),
        .pwr_valid_o (pwr_valid),
        .busy_o      (busy),
        .peak_out_o  (peak_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint pwr;
        int     peak;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    logic   rst_edge = 1'b1;

    // Reference model: the raw samples of the open window, plus its exponent.
    bit     m_known = 0;
    bit     m_busy  = 0;
    int     m_n     = 4;
    int     win[$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int clamp_n(int n);
        if (n < 4)  return 4;
        if (n > 12) return 12;
        return n;
    endfunction

    function automatic int mag_sat(int s);
        int a;
        a = (s < 0) ? -s : s;
        return (a > 32767) ? 32767 : a;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = reset;
        end
    end

    // Monitor: compares every pulse against the scoreboard and checks holds.
    initial begin
        bit     known = 0;
        longint hold_pwr = 0;
        int     hold_pk  = 0;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (!rst_edge) begin
                known    = 1;
                hold_pwr = 0;
                hold_pk  = 0;
                chk("rst_pwr_out", 64'(pwr_out), 64'd0);
                chk("rst_pwr_valid", 64'(pwr_valid), 64'd0);
                chk("rst_peak_out", 64'(peak_out), 64'd0);
            end else if (known) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk("missing_pulse_at_cycle", 64'(cyc), 64'(e.cyc));
                end
                if (pwr_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("spurious_pwr_valid", 64'(pwr_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                        chk("pwr_out", 64'(pwr_out), 64'(e.pwr));
                        chk("peak_out", 64'(peak_out), 64'(e.peak));
                        hold_pwr = e.pwr;
                        hold_pk  = e.peak;
                    end
                end else begin
                    chk("pwr_valid_low", 64'(pwr_valid), 64'd0);
                    chk("pwr_out_hold", 64'(pwr_out), 64'(hold_pwr));
                    chk("peak_out_hold", 64'(peak_out), 64'(hold_pk));
                end
            end
        end
    end

    // One clock of stimulus; the model predicts what the next edge does.
    task automatic step(input int d, input bit v, input bit st, input bit ct,
                        input bit e, input int wl, input bit r);
        longint sum;
        int     pk;
        exp_t   x;
        @(negedge clk);
        if (m_known) chk("busy", 64'(busy), 64'(m_busy));
        in_d     = 16'(d);
        in_valid = v;
        start    = st;
        cont     = ct;
        en       = e;
        win_log2 = 4'(wl);
        reset    = r;
        if (!r) begin
            m_known = 1;
            m_busy  = 0;
            win.delete();
        end else if (!m_busy) begin
            if (st && e) begin
                m_busy = 1;
                m_n    = clamp_n(wl);
                win.delete();
            end
        end else if (!e) begin
            m_busy = 0;
            win.delete();
        end else if (v) begin
            win.push_back(int'($signed(16'(d))));
            if (win.size() == (1 << m_n)) begin
                sum = 0;
                pk  = 0;
                foreach (win[i]) begin
                    sum += longint'(win[i]) * longint'(win[i]);
                    if (mag_sat(win[i]) > pk) pk = mag_sat(win[i]);
                end
                x.pwr = sum >> m_n;
`ifdef RX_PWR_PEAK_EN
                x.peak = pk;
`else
                x.peak = 0;
`endif
                x.cyc = cyc + 1;
                sb.push_back(x);
                win.delete();
                if (ct) m_n = clamp_n(wl);
                else    m_busy = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step($urandom, 0, 0, 0, 1, $urandom_range(0, 15), 1);
    endtask

    initial begin
        reset = 1'b0; in_d = '0; in_valid = 0; start = 0; cont = 0; en = 0; win_log2 = 4'd4;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 4, 0);
        idle(2);

        // Constant 1000, one-shot 16-sample window.
        step(0, 0, 1, 0, 1, 4, 1);
        for (int i = 0; i < 16; i++) step(1000, 1, 0, 0, 1, 4, 1);
        idle(3);

        // Full-scale negative input over the largest window.
        step(0, 0, 1, 0, 1, 12, 1);
        for (int i = 0; i < 4096; i++) step(-32768, 1, 0, 0, 1, 12, 1);
        idle(3);

        // Exponent below minimum clamps; gaps stall the count; win_log2 churns.
        step(0, 0, 1, 0, 1, 2, 1);
        for (int i = 0; i < 32; i++)
            step((i % 2 == 0) ? 100 : $urandom, (i % 2 == 0), 0, 0, 1, $urandom_range(0, 15), 1);
        idle(3);

        // Continuous ramp; cont drops mid third window, which still completes.
        step(0, 0, 1, 1, 1, 4, 1);
        for (int i = 0; i < 48; i++) step(i, 1, 0, (i < 40), 1, 4, 1);
        idle(3);

        // Abort at sample 10, then a fresh window.
        step(0, 0, 1, 0, 1, 4, 1);
        for (int i = 0; i < 10; i++) step(500, 1, 0, 0, 1, 4, 1);
        step(500, 1, 0, 0, 0, 4, 1);
        idle(3);
        step(0, 0, 1, 0, 1, 4, 1);
        for (int i = 0; i < 16; i++) step(300 + i, 1, 1, 0, 1, 4, 1);
        idle(3);

        // Reset mid-window, then a clean window.
        step(0, 0, 1, 0, 1, 5, 1);
        for (int i = 0; i < 7; i++) step(20000, 1, 0, 0, 1, 5, 1);
        step(0, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 1, 5, 0);
        idle(2);
        step(0, 0, 1, 0, 1, 5, 1);
        for (int i = 0; i < 32; i++) step(-7 * i, 1, 0, 0, 1, 5, 1);
        idle(3);

        // Exponent above maximum clamps to 4096 samples.
        step(0, 0, 1, 0, 1, 15, 1);
        for (int i = 0; i < 4096; i++) step($urandom, 1, 0, 0, 1, 15, 1);
        idle(3);

        // Random traffic: starts, cont, gaps, rare aborts, churning exponent.
        for (int i = 0; i < 4000; i++)
            step($urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 1), ($urandom_range(0, 199) != 0), $urandom_range(0, 6), 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 4, 1);
        idle(3);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
